// File: rtl/sdram_init_refresh_sequencer_if.sv
// Command bus and refresh handshake shared by the init/refresh sequencer and the SDRAM controller.
// The sequencer side is the master; the controller/SDRAM side is the slave.
interface sdram_init_refresh_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BANK_WIDTH = 2
);
    logic                  init_done_port;
    logic                  refresh_req_port;
    logic                  refresh_urgent_port;
    logic                  refresh_grant_port;
    logic                  refresh_active_port;
    logic [3:0]            pending_count_port;
    logic                  overflow_port;
    logic                  ram_side_cs_n_port;
    logic                  ram_side_ras_n_port;
    logic                  ram_side_cas_n_port;
    logic                  ram_side_wr_en_port;
    logic [ADDR_WIDTH-1:0] ram_side_addr_port;
    logic [BANK_WIDTH-1:0] ram_side_bank_addr_port;
    logic                  ram_side_ck_en_port;

    modport master (
        output init_done_port, refresh_req_port, refresh_urgent_port, refresh_active_port,
               pending_count_port, overflow_port, ram_side_cs_n_port, ram_side_ras_n_port,
               ram_side_cas_n_port, ram_side_wr_en_port, ram_side_addr_port,
               ram_side_bank_addr_port, ram_side_ck_en_port,
        input  refresh_grant_port
    );

    modport slave (
        input  init_done_port, refresh_req_port, refresh_urgent_port, refresh_active_port,
               pending_count_port, overflow_port, ram_side_cs_n_port, ram_side_ras_n_port,
               ram_side_cas_n_port, ram_side_wr_en_port, ram_side_addr_port,
               ram_side_bank_addr_port, ram_side_ck_en_port,
        output refresh_grant_port
    );
endinterface

// File: rtl/sdram_init_refresh_sequencer.sv
// SDRAM power-up initialisation and periodic auto-refresh engine with bounded postponement.
// Owns the command bus during init and refresh bursts; otherwise hands it to the controller.
module sdram_init_refresh_sequencer #(
    parameter int unsigned POWERUP_CYCLES        = 16000,
    parameter int unsigned T_RP_CYCLES           = 2,
    parameter int unsigned T_RFC_CYCLES          = 6,
    parameter int unsigned T_MRD_CYCLES          = 2,
    parameter int unsigned INIT_REFRESH_COUNT    = 8,
    parameter int unsigned REFRESH_PERIOD_CYCLES = 624,
    parameter int unsigned MAX_POSTPONE          = 8,
    parameter int unsigned ADDR_WIDTH            = 12,
    parameter int unsigned BANK_WIDTH            = 2,
    parameter logic [ADDR_WIDTH-1:0] MODE_REG_VALUE = 12'h020
) (
    input logic                            clk,
    input logic                            reset_port,
    sdram_init_refresh_sequencer_if.master bus_io
);
    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;
    localparam logic [3:0] CmdMrs = 4'b0000;

    localparam int unsigned GapA     = (T_RP_CYCLES > T_RFC_CYCLES) ? T_RP_CYCLES : T_RFC_CYCLES;
    localparam int unsigned GapB     = (GapA > T_MRD_CYCLES) ? GapA : T_MRD_CYCLES;
    localparam int unsigned TimerMax = (POWERUP_CYCLES > GapB) ? POWERUP_CYCLES : GapB;
    localparam int unsigned TW       = $clog2(TimerMax + 1);
    localparam int unsigned IW       = $clog2(INIT_REFRESH_COUNT + 1);
    localparam int unsigned RW       = $clog2(REFRESH_PERIOD_CYCLES + 1);

    localparam logic [TW-1:0] PowerupLast = TW'(POWERUP_CYCLES);
    localparam logic [TW-1:0] RpLoad      = TW'(T_RP_CYCLES - 1);
    localparam logic [TW-1:0] RfcLoad     = TW'(T_RFC_CYCLES - 1);
    localparam logic [TW-1:0] MrdLoad     = TW'(T_MRD_CYCLES - 1);
    localparam logic [IW-1:0] InitRefs    = IW'(INIT_REFRESH_COUNT);
    localparam logic [RW-1:0] TrefiLast   = RW'(REFRESH_PERIOD_CYCLES - 1);
    localparam logic [3:0]    MaxPend     = 4'(MAX_POSTPONE);
    localparam logic [ADDR_WIDTH-1:0] PreAllAddr = ADDR_WIDTH'(1024);

    typedef enum logic [2:0] {
        StPowerup, StInitRp, StInitRfc, StInitMrd, StIdle, StRefRp, StRefRfc
    } state_e;

    state_e                state_q;
    logic [TW-1:0]         timer_q;
    logic [IW-1:0]         init_refs_q;
    logic [RW-1:0]         trefi_q;
    logic [3:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BANK_WIDTH-1:0] bank_q;
    logic                  cke_q, init_done_q, active_q, req_q, urgent_q, overflow_q;
    logic [3:0]            pending_q, pending_d;
    logic                  overflow_d, tick, timer_done, ref_issue;

    // A tick and a refresh issued in the same cycle cancel out.
    always_comb begin
        tick       = init_done_q && (trefi_q == TrefiLast);
        timer_done = (timer_q == '0);
        ref_issue  = timer_done && ((state_q == StRefRp) ||
                                    ((state_q == StRefRfc) && (pending_q != '0)));
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick && !ref_issue) begin
            if (pending_q == MaxPend) overflow_d = 1'b1;
            else                      pending_d  = pending_q + 4'd1;
        end else if (!tick && ref_issue) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_port) begin
            state_q     <= StPowerup;
            timer_q     <= '0;
            init_refs_q <= '0;
            trefi_q     <= '0;
            cmd_q       <= CmdNop;
            addr_q      <= '0;
            bank_q      <= '0;
            cke_q       <= 1'b0;
            init_done_q <= 1'b0;
            active_q    <= 1'b1;
            req_q       <= 1'b0;
            urgent_q    <= 1'b0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            cmd_q      <= CmdNop;
            addr_q     <= '0;
            bank_q     <= '0;
            cke_q      <= 1'b1;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            req_q      <= (pending_d != '0);
            urgent_q   <= (pending_d == MaxPend);
            if (init_done_q) trefi_q <= tick ? '0 : trefi_q + RW'(1);

            unique case (state_q)
                StPowerup: begin
                    if (timer_q == PowerupLast) begin
                        cmd_q   <= CmdPre;
                        addr_q  <= PreAllAddr;
                        timer_q <= RpLoad;
                        state_q <= StInitRp;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StInitRp: begin
                    if (timer_done) begin
                        cmd_q       <= CmdRef;
                        init_refs_q <= init_refs_q + IW'(1);
                        timer_q     <= RfcLoad;
                        state_q     <= StInitRfc;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                StInitRfc: begin
                    if (!timer_done) begin
                        timer_q <= timer_q - TW'(1);
                    end else if (init_refs_q == InitRefs) begin
                        cmd_q   <= CmdMrs;
                        addr_q  <= MODE_REG_VALUE;
                        timer_q <= MrdLoad;
                        state_q <= StInitMrd;
                    end else begin
                        cmd_q       <= CmdRef;
                        init_refs_q <= init_refs_q + IW'(1);
                        timer_q     <= RfcLoad;
                    end
                end
                StInitMrd: begin
                    if (timer_done) begin
                        init_done_q <= 1'b1;
                        active_q    <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                StIdle: begin
                    if (req_q && bus_io.refresh_grant_port) begin
                        cmd_q    <= CmdPre;
                        addr_q   <= PreAllAddr;
                        active_q <= 1'b1;
                        timer_q  <= RpLoad;
                        state_q  <= StRefRp;
                    end
                end
                StRefRp: begin
                    if (timer_done) begin
                        cmd_q   <= CmdRef;
                        timer_q <= RfcLoad;
                        state_q <= StRefRfc;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                StRefRfc: begin
                    if (!timer_done) begin
                        timer_q <= timer_q - TW'(1);
                    end else if (pending_q != '0) begin
                        cmd_q   <= CmdRef;
                        timer_q <= RfcLoad;
                    end else begin
                        active_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StPowerup;
            endcase
        end
    end

    assign {bus_io.ram_side_cs_n_port, bus_io.ram_side_ras_n_port,
            bus_io.ram_side_cas_n_port, bus_io.ram_side_wr_en_port} = cmd_q;
    assign bus_io.ram_side_addr_port      = addr_q;
    assign bus_io.ram_side_bank_addr_port = bank_q;
    assign bus_io.ram_side_ck_en_port     = cke_q;
    assign bus_io.init_done_port          = init_done_q;
    assign bus_io.refresh_active_port     = active_q;
    assign bus_io.refresh_req_port        = req_q;
    assign bus_io.refresh_urgent_port     = urgent_q;
    assign bus_io.pending_count_port      = pending_q;
    assign bus_io.overflow_port           = overflow_q;
endmodule
